// File: rtl/wasca_div_pkg.sv
// Shared types and constants for the NIOS II sequential divide cell.
package wasca_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/wasca_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit and
// subtract the divisor when the shifted partial remainder is not smaller.
module wasca_div_step
  import wasca_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted  = {rem_in, bit_in};
  assign quot_bit = (shifted >= {1'b0, divisor});
  // When the subtraction succeeds the true difference is below the divisor,
  // so the low WIDTH bits of the modular difference are exact.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign rem_out  = quot_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/wasca_nios2_gen2_0_cpu_div_cell.sv
// Sequential signed/unsigned 32-bit divider: sign-magnitude restoring
// division, one quotient bit per enabled clock, with divide-by-zero bypass.
module wasca_nios2_gen2_0_cpu_div_cell
  import wasca_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_signed,
  input  logic             E_div_start,
  input  logic             M_en,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic             M_div_by_zero
);

  div_state_t           state_reg, state_next;
  logic [DIV_CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]     work_reg, work_next;
  logic [WIDTH-1:0]     part_reg, part_next;
  logic [WIDTH-1:0]     dvsr_reg, dvsr_next;
  logic [WIDTH-1:0]     quot_reg, quot_next;
  logic [WIDTH-1:0]     rem_reg, rem_next;
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic                 by_zero_reg, by_zero_next;

  logic                 src1_neg, src2_neg;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;

  assign src1_neg = E_div_signed & E_src1[WIDTH-1];
  assign src2_neg = E_div_signed & E_src2[WIDTH-1];
  assign mag1     = src1_neg ? (~E_src1 + 1'b1) : E_src1;
  assign mag2     = src2_neg ? (~E_src2 + 1'b1) : E_src2;

  // work_reg shifts the dividend out at the top and the quotient in at the bottom.
  wasca_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (part_reg),
    .divisor  (dvsr_reg),
    .bit_in   (work_reg[WIDTH-1]),
    .rem_out  (step_rem),
    .quot_bit (step_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      part_reg    <= '0;
      dvsr_reg    <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      by_zero_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      work_reg    <= work_next;
      part_reg    <= part_next;
      dvsr_reg    <= dvsr_next;
      quot_reg    <= quot_next;
      rem_reg     <= rem_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      by_zero_reg <= by_zero_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    work_next    = work_reg;
    part_next    = part_reg;
    dvsr_next    = dvsr_reg;
    quot_next    = quot_reg;
    rem_next     = rem_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    by_zero_next = by_zero_reg;
    if (M_en) begin
      case (state_reg)
        DIV_IDLE: begin
          if (E_div_start) begin
            by_zero_next = (E_src2 == '0);
            neg_q_next   = src1_neg ^ src2_neg;
            neg_r_next   = src1_neg;
            dvsr_next    = mag2;
            part_next    = '0;
            cnt_next     = DIV_CNT_W'(WIDTH - 1);
            // A zero divisor keeps the raw dividend for the remainder output.
            if (E_src2 == '0) begin
              work_next  = E_src1;
              state_next = DIV_FIX;
            end else begin
              work_next  = mag1;
              state_next = DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          part_next = step_rem;
          work_next = {work_reg[WIDTH-2:0], step_q};
          if (cnt_reg == '0) begin
            state_next = DIV_FIX;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        DIV_FIX: begin
          if (by_zero_reg) begin
            quot_next = '1;
            rem_next  = work_reg;
          end else begin
            quot_next = neg_q_reg ? (~work_reg + 1'b1) : work_reg;
            rem_next  = neg_r_reg ? (~part_reg + 1'b1) : part_reg;
          end
          state_next = DIV_DONE;
        end
        DIV_DONE: state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  assign M_div_quot    = quot_reg;
  assign M_div_rem     = rem_reg;
  assign M_div_busy    = (state_reg != DIV_IDLE);
  assign M_div_done    = (state_reg == DIV_DONE);
  assign M_div_by_zero = by_zero_reg;

endmodule

// File: doc/wasca_nios2_gen2_0_cpu_div_cell.md
WASCA_NIOS2_GEN2_0_CPU_DIV_CELL -- requirements
Module: wasca_nios2_gen2_0_cpu_div_cell

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: E_src1  input  WIDTH  dividend; sampled on the start edge only.
REQ-005 Port: E_src2  input  WIDTH  divisor; sampled on the start edge only.
REQ-006 Port: E_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the start edge.
REQ-007 Port: E_div_start  input  1  request pulse; accepted only when idle and M_en=1.
REQ-008 Port: M_en  input  1  stall enable; 0 freezes all state (same meaning as the multiplier cell enable).
REQ-009 Port: M_div_quot  output  WIDTH  quotient, valid from done until the next accepted start.
REQ-010 Port: M_div_rem  output  WIDTH  remainder, same validity as quotient.
REQ-011 Port: M_div_busy  output  1  high from the edge after the start edge until done deasserts.
REQ-012 Port: M_div_done  output  1  one-cycle result-valid pulse.
REQ-013 Port: M_div_by_zero  output  1  divisor was zero; held with results.

Function
REQ-014 FSM states: IDLE, RUN, FIX, DONE; encoding is implementation-defined.
REQ-015 IDLE->RUN on clk edge with E_div_start=1, M_en=1, divisor nonzero; operand magnitudes, sign flags and step counter (WIDTH-1) are latched.
REQ-016 RUN: one restoring radix-2 step per enabled edge (shift remainder left, bring in next dividend MSB, subtract divisor magnitude when no borrow, shift in quotient bit); exit to FIX after exactly WIDTH steps.
REQ-017 FIX: one enabled edge; negate quotient if signed and operand signs differ; negate remainder if signed and dividend negative; unsigned mode skips negation.
REQ-018 DONE: M_div_done=1 for exactly one enabled cycle, then IDLE; results hold until the next accepted start.
REQ-019 Latency with M_en held 1: done is high in the cycle after the (WIDTH+2)-th rising edge following, and including, the start edge (34 cycles for WIDTH=32).
REQ-020 Divisor zero at start: IDLE->FIX->DONE (skipping RUN); quotient all ones, remainder = E_src1 unmodified, M_div_by_zero=1; cleared on the next accepted start.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no flag.
REQ-022 E_div_start while busy or done is ignored; no queueing.
REQ-023 M_en=0 in any state: state, counter and outputs hold; done stays high while stalled in DONE.
REQ-024 Arithmetic: WIDTH+1-bit partial remainder; all results truncated to WIDTH bits; no saturation.

Reset
REQ-025 reset_n=0 forces IDLE immediately, regardless of clk or M_en, and aborts any in-flight division.
REQ-026 Reset values: M_div_quot=0, M_div_rem=0, M_div_busy=0, M_div_done=0, M_div_by_zero=0, counter=0.
REQ-027 After reset_n rises, the first enabled edge with E_div_start=1 is accepted normally.

Structure
REQ-028 Package wasca_div_pkg holds the FSM state type, the WIDTH default and the counter width constant (clog2 of WIDTH).
REQ-029 One sub-module, wasca_div_step, is combinational: one restoring step (remainder in/out, divisor, next bit, quotient bit out).
REQ-030 No vendor multiplier/divider primitives; fabric logic only.

Verification
REQ-031 Unsigned 100/7, M_en=1 -> done at cycle 34; quot=14, rem=2, by_zero=0.
REQ-032 Signed 0xFFFFFF9C (-100) / 7 -> quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2); 100 / -7 -> quot=-14, rem=2.
REQ-033 Divide by zero: 0x12345678/0 -> done at cycle 2, quot=0xFFFFFFFF, rem=0x12345678, by_zero=1; the next valid start clears the flag.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rem=0.
REQ-035 Stall and busy: M_en=0 for 5 cycles mid-RUN -> done at cycle 39 with correct result; start pulses during busy produce no effect.
REQ-036 Reset mid-RUN at step 10 -> all outputs 0 immediately; a fresh start afterwards gives the correct result in 34 cycles.
